nes_dual_poller: RTL and testbench

Sequences the shared latch and clock lines of two NES controllers, which are wired to the bidirectional PMOD pins. Each poll shifts in 8 buttons per pad. A poll is triggered by a one-cycle `start` pulse, normally the frame/vsync tick from the VGA timing block. The block presents registered, active-high button vectors to the Pong game logic, plus a one-cycle `valid` strobe when a poll completes. It replaces ad-hoc shift logic inside the game core and is the only driver of `nes_latch` and `nes_clk`.

---
 rtl/nes_dual_poller.sv | 112 +++++++++++
 tb/tb_nes_dual_poller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_dual_poller.sv
// Polls two NES controllers over a shared latch/clock pair and presents
// registered active-high button vectors with a one-cycle valid strobe.
module nes_dual_poller #(
    parameter int CLK_DIV = 150
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       nes_data_a,
    input  logic       nes_data_b,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons_a,
    output logic [7:0] buttons_b,
    output logic       valid,
    output logic       busy
);

    // Wide enough to hold 2*CLK_DIV-1, the last cycle of the latch pulse.
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic            phase_end;
    logic [1:0]      sync_a;
    logic [1:0]      sync_b;
    logic [6:0]      shift_a;
    logic [6:0]      shift_b;

    always_comb begin
        // NOTE: assign every comb output a default first so no path can infer a latch.
        phase_end = 1'b0;
        case (state)
            LATCH:     phase_end = (cnt == LATCH_LAST);
            LOW, HIGH: phase_end = (cnt == HALF_LAST);
            default:   phase_end = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LATCH;
            LATCH:   if (phase_end) state_next = LOW;
            LOW:     if (phase_end) state_next = (idx == 3'd7) ? DONE : HIGH;
            HIGH:    if (phase_end) state_next = LOW;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sync_a    <= 2'b11;
            sync_b    <= 2'b11;
            shift_a   <= '1;
            shift_b   <= '1;
            buttons_a <= '0;
            buttons_b <= '0;
        end else begin
            state  <= state_next;
            sync_a <= {sync_a[0], nes_data_a};
            sync_b <= {sync_b[0], nes_data_b};

            if (state_next != state)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;

            if (state == LATCH)
                idx <= '0;
            else if (state == HIGH && phase_end)
                idx <= idx + 1'b1;

            // Bits 0..6 accumulate LSB-first; bit 7 goes straight into the
            // button registers on the edge that enters DONE.
            if (state == LOW && phase_end) begin
                shift_a <= {sync_a[1], shift_a[6:1]};
                shift_b <= {sync_b[1], shift_b[6:1]};
                if (idx == 3'd7) begin
                    buttons_a <= ~{sync_a[1], shift_a};
                    buttons_b <= ~{sync_b[1], shift_b};
                end
            end
        end
    end

    always_comb begin
        nes_latch = (state == LATCH);
        nes_clk   = (state != LOW);
        busy      = (state != IDLE);
        valid     = (state == DONE);
    end

endmodule

// File: tb/tb_nes_dual_poller.sv
// Randomised self-checking bench for nes_dual_poller: behavioural pad models
// plus timing expectations derived from the poll schedule.
module tb_nes_dual_poller;

    localparam int D  = 4;
    localparam int D2 = 150;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       da, db;
    logic       latch, nclk, valid, busy;
    logic [7:0] ba, bb;

    logic       start2 = 1'b0;
    logic       d2_line = 1'b1;
    logic       latch2, nclk2, valid2, busy2;
    logic [7:0] ba2, bb2;

    int n_checks = 0;
    int n_errors = 0;

    // Pad model: latches the pressed pattern, advances one bit per clock rise.
    logic [7:0] pressed_a = 8'h00, pressed_b = 8'h00;
    logic [7:0] lat_a = 8'h00, lat_b = 8'h00;
    bit         present_a = 1'b1, present_b = 1'b1;
    int         pad_idx = 8;

    always #5 clk = ~clk;

    nes_dual_poller #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .start(start),
        .nes_data_a(da), .nes_data_b(db),
        .nes_latch(latch), .nes_clk(nclk),
        .buttons_a(ba), .buttons_b(bb),
        .valid(valid), .busy(busy)
    );

    nes_dual_poller #(.CLK_DIV(D2)) dut_def (
        .clk(clk), .reset(reset), .start(start2),
        .nes_data_a(d2_line), .nes_data_b(d2_line),
        .nes_latch(latch2), .nes_clk(nclk2),
        .buttons_a(ba2), .buttons_b(bb2),
        .valid(valid2), .busy(busy2)
    );

    function automatic logic pad_bit(input logic [7:0] v, input int i);
        if (i >= 0 && i < 8) return v[i[2:0]];
        return 1'b0;
    endfunction

    always @(posedge latch) begin
        pad_idx = 0;
        lat_a   = pressed_a;
        lat_b   = pressed_b;
    end

    always @(posedge nclk) if (!latch) pad_idx = pad_idx + 1;

    assign da = present_a ? ~pad_bit(lat_a, pad_idx) : 1'b1;
    assign db = present_b ? ~pad_bit(lat_b, pad_idx) : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One poll on the CLK_DIV=4 instance. Period n=1 is the cycle after the
    // edge that accepted start.
    task automatic run_poll(input logic [7:0] exp_a, input logic [7:0] exp_b,
                            input bit inject, input bit b2b);
        int n = 1;
        int last_n = b2b ? 17 * D + 1 : 17 * D + 40;
        int latch_cnt = 0, latch_last = 0, valid_cnt = 0, valid_at = 0;
        int busy_cnt = 0, falls = 0, low_len = 0, bad_low = 0;
        logic prev_clk = 1'b1;
        logic [7:0] got_a = 8'hxx, got_b = 8'hxx;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (1) begin
            if (latch) begin latch_cnt++; latch_last = n; end
            if (!nclk) low_len++;
            if (prev_clk && !nclk) falls++;
            if (!prev_clk && nclk) begin
                if (low_len != D) bad_low++;
                low_len = 0;
            end
            if (valid) begin valid_cnt++; valid_at = n; got_a = ba; got_b = bb; end
            if (busy) busy_cnt++;
            prev_clk = nclk;
            if (n == last_n) break;
            start = (inject && (n == 10 || n == 17 * D + 1));
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latch_width", latch_cnt, 2 * D);
        check("latch_end", latch_last, 2 * D);
        check("clk_falls", falls, 8);
        check("clk_low_len", bad_low, 0);
        check("valid_count", valid_cnt, 1);
        check("valid_time", valid_at, 17 * D + 1);
        check("busy_len", busy_cnt, 17 * D + 1);
        check("buttons_a", got_a, exp_a);
        check("buttons_b", got_b, exp_b);
        if (!b2b) begin
            check("hold_a", ba, exp_a);
            check("hold_b", bb, exp_b);
        end
    endtask

    task automatic set_pads(input logic [7:0] pa, input logic [7:0] pb,
                            input bit pres_a, input bit pres_b);
        pressed_a = pa;
        pressed_b = pb;
        present_a = pres_a;
        present_b = pres_b;
    endtask

    initial begin
        int bad;
        int n;
        int cnt_v, cnt_l;

        // Reset and idle stability
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_latch", latch, 1'b0);
        check("rst_clk", nclk, 1'b1);
        check("rst_buttons_a", ba, 8'h00);
        check("rst_buttons_b", bb, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (latch !== 1'b0 || nclk !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 ||
                ba !== 8'h00 || bb !== 8'h00) bad++;
        end
        check("idle_stable", bad, 0);

        // Basic poll
        set_pads(8'h81, 8'h08, 1'b1, 1'b1);
        run_poll(8'h81, 8'h08, 1'b0, 1'b0);

        // Busy rejection, including a start in the DONE cycle
        set_pads(8'h3c, 8'hc5, 1'b1, 1'b1);
        run_poll(8'h3c, 8'hc5, 1'b1, 1'b0);

        // Reset mid-shift
        set_pads(8'h55, 8'haa, 1'b1, 1'b1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        while (n < 40) begin @(negedge clk); n++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_latch", latch, 1'b0);
        check("midrst_clk", nclk, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_buttons_a", ba, 8'h00);
        check("midrst_buttons_b", bb, 8'h00);
        cnt_v = 0;
        cnt_l = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid) cnt_v++;
            if (latch || busy) cnt_l++;
        end
        check("midrst_no_valid", cnt_v, 0);
        check("midrst_quiet", cnt_l, 0);
        run_poll(8'h55, 8'haa, 1'b0, 1'b0);

        // Absent pads, back-to-back polls
        set_pads(8'hff, 8'hff, 1'b0, 1'b0);
        run_poll(8'h00, 8'h00, 1'b0, 1'b1);
        run_poll(8'h00, 8'h00, 1'b0, 1'b0);

        // Randomised pad contents and presence
        for (int k = 0; k < 8; k++) begin
            logic [7:0] pa, pb;
            bit         qa, qb;
            pa = 8'($urandom);
            pb = 8'($urandom);
            qa = ($urandom_range(0, 3) != 0);
            qb = ($urandom_range(0, 3) != 0);
            set_pads(pa, pb, qa, qb);
            run_poll(qa ? pa : 8'h00, qb ? pb : 8'h00, k[0], 1'b0);
        end

        // Default CLK_DIV: latch width, phase lengths, valid latency
        begin
            int lcnt = 0, low_tot = 0, high_tot = 0, vat = 0, vcnt = 0;
            int run = 0, bad_run = 0;
            logic prev = 1'b1;
            @(negedge clk) start2 = 1'b1;
            @(negedge clk) start2 = 1'b0;
            for (int m = 1; m <= 17 * D2 + 40; m++) begin
                if (latch2) lcnt++;
                if (!nclk2) low_tot++;
                if (busy2 && nclk2 && !latch2 && !valid2) high_tot++;
                if (valid2) begin vcnt++; vat = m; end
                if (nclk2 != prev && m > 1) begin
                    if (run != D2 && !(prev && run == 2 * D2)) bad_run++;
                    run = 0;
                end
                if (busy2 && !valid2) run++;
                prev = nclk2;
                if (m < 17 * D2 + 40) @(negedge clk);
            end
            check("def_latch_width", lcnt, 2 * D2);
            check("def_low_total", low_tot, 8 * D2);
            check("def_high_total", high_tot, 7 * D2);
            check("def_phase_len", bad_run, 0);
            check("def_valid_count", vcnt, 1);
            check("def_valid_time", vat, 17 * D2 + 1);
            check("def_buttons", {ba2, bb2}, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
